zxbus_int_gen: RTL

Interrupt generator between the card's control/status port register block and the ZX bus /INT line. It synchronises the W5300 and SL811 interrupt requests, masks them with the per-source enables from port #83AB, and returns the combined `internal_int` status bit for the #83AB read path. When the ZX bus interrupt enable is set, it drives a fixed-width, acknowledge-terminated active-low /INT pulse onto the bus, with a mandatory holdoff gap between pulses.

---
 rtl/zxbus_int_gen.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/zxbus_int_gen.sv
`default_nettype none
// ============================================================================
// Module   : zxbus_int_gen
// Purpose  : ZX bus /INT generator. Synchronises the W5300 and SL811
//            interrupt requests and masks them with their per-source enables.
//            The result is internal_int, which feeds bit 7 of the #83AB read
//            data. A rising edge of internal_int produces one fixed-width,
//            acknowledge-terminated active-low /INT pulse. A mandatory
//            holdoff gap follows every pulse.
// Ports    : clk, rst                 - clock, async active-high reset
//            w5300_int_n, sl811_intrq - interrupt sources (async)
//            ena_w5300_int, ena_sl811_int, ena_zxbus_int - enables (async)
//            zx_m1_n, zx_iorq_n       - Z80 interrupt acknowledge (async)
//            internal_int             - masked OR of the sources
//            zx_int_n                 - /INT drive, active low
//            int_busy                 - state machine in ASSERT or HOLDOFF
// Config   : ZXBUS_INT_RETRIGGER_EN   - when defined, a source level still
//            high at the end of HOLDOFF starts another pulse.
// Revision : 1.0 - initial release
// ============================================================================
module zxbus_int_gen #(
  parameter int unsigned INT_LEN = 256,
  parameter int unsigned HOLDOFF = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic w5300_int_n,
  input  logic sl811_intrq,
  input  logic ena_w5300_int,
  input  logic ena_sl811_int,
  input  logic ena_zxbus_int,
  input  logic zx_m1_n,
  input  logic zx_iorq_n,
  output logic internal_int,
  output logic zx_int_n,
  output logic int_busy
);

  localparam logic [11:0] C_INT_LOAD  = 12'(INT_LEN - 1);
  localparam logic [11:0] C_HOLD_LOAD = 12'(HOLDOFF - 1);
  // Synchroniser bit order: {iorq_n, m1_n, ena_zx, ena_sl, ena_w, sl_irq, w_int_n}.
  // The active-low inputs reset to 1 so that they reset to the inactive level.
  localparam logic [6:0]  C_SYNC_RST  = 7'b110_0001;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  logic [6:0]  sync1_d, sync1_q, sync2_d, sync2_q;
  state_t      state_d, state_q;
  logic [11:0] cnt_d, cnt_q;
  logic        zx_int_n_d, zx_int_n_q;
  logic        pending_d, pending_q;
  logic        int_prev_d, int_prev_q;
  logic        start_pulse;

  logic w5300_int_n_s, sl811_intrq_s, ena_w5300_int_s, ena_sl811_int_s;
  logic ena_zxbus_int_s, zx_m1_n_s, zx_iorq_n_s;
  logic w_req, s_req, trig, ack, retrig;

  always_comb begin
    sync1_d = {zx_iorq_n, zx_m1_n, ena_zxbus_int, ena_sl811_int,
               ena_w5300_int, sl811_intrq, w5300_int_n};
    sync2_d = sync1_q;
  end

  assign {zx_iorq_n_s, zx_m1_n_s, ena_zxbus_int_s, ena_sl811_int_s,
          ena_w5300_int_s, sl811_intrq_s, w5300_int_n_s} = sync2_q;

  assign w_req        = ~w5300_int_n_s & ena_w5300_int_s;
  assign s_req        = sl811_intrq_s & ena_sl811_int_s;
  // Built only from synchronised flops, so it cannot glitch on pin activity.
  assign internal_int = w_req | s_req;
  assign int_prev_d   = internal_int;
  assign trig         = internal_int & ~int_prev_q;
  assign ack          = ~zx_m1_n_s & ~zx_iorq_n_s;

`ifdef ZXBUS_INT_RETRIGGER_EN
  assign retrig = internal_int;
`else
  assign retrig = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    zx_int_n_d  = zx_int_n_q;
    start_pulse = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ena_zxbus_int_s && (pending_q || trig)) start_pulse = 1'b1;
      end
      ST_ASSERT: begin
        // Counter expiry, acknowledge and enable drop all end the pulse the
        // same way, so they collapse into a single transition.
        if ((cnt_q == 12'd0) || ack || !ena_zxbus_int_s) begin
          state_d    = ST_HOLDOFF;
          cnt_d      = C_HOLD_LOAD;
          zx_int_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == 12'd0) begin
          // A trig in this same cycle restarts directly without losing a cycle.
          if (ena_zxbus_int_s && (pending_q || trig || retrig)) start_pulse = 1'b1;
          else                                                  state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        zx_int_n_d = 1'b1;
      end
    endcase

    if (start_pulse) begin
      state_d    = ST_ASSERT;
      cnt_d      = C_INT_LOAD;
      zx_int_n_d = 1'b0;
    end

    // Pending records edges that arrive while a pulse or holdoff is running.
    // Further edges collapse into the same single pending pulse.
    if (!ena_zxbus_int_s || start_pulse) pending_d = 1'b0;
    else if (trig)                       pending_d = 1'b1;
    else                                 pending_d = pending_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= C_SYNC_RST;
      sync2_q    <= C_SYNC_RST;
      state_q    <= ST_IDLE;
      cnt_q      <= 12'd0;
      zx_int_n_q <= 1'b1;
      pending_q  <= 1'b0;
      int_prev_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      zx_int_n_q <= zx_int_n_d;
      pending_q  <= pending_d;
      int_prev_q <= int_prev_d;
    end
  end

  assign zx_int_n = zx_int_n_q;
  assign int_busy = (state_q != ST_IDLE);

endmodule
`default_nettype wire
